// File: rtl/key_press_conditioner_if.sv
// Player-key bundle between the raw pushbuttons and the conditioner:
// active-low keys and the game-over lock in, one-cycle L/R press pulses out.
interface key_press_conditioner_if;
    logic key_l_n;
    logic key_r_n;
    logic lock;
    logic L;
    logic R;

    modport master (
        output key_l_n,
        output key_r_n,
        output lock,
        input  L,
        input  R
    );

    modport slave (
        input  key_l_n,
        input  key_r_n,
        input  lock,
        output L,
        output R
    );
endinterface

// File: rtl/key_press_conditioner.sv
// Synchronizes and debounces the two active-low player keys and emits one
// single-cycle L/R pulse per accepted press, suppressed while the game is locked.
module key_press_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    key_press_conditioner_if.slave  keys
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    // Channel 0 is the left key, channel 1 the right key.
    logic [1:0]       raw_press;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       pulse;
    logic [1:0]       pulse_next;
    state_t           state      [2];
    state_t           state_next [2];
    logic [CNT_W-1:0] cnt        [2];
    logic [CNT_W-1:0] cnt_next   [2];

    assign raw_press = {~keys.key_r_n, ~keys.key_l_n};

    // State register: synchronizers, FSMs, counters and pulse flops.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            pulse <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= IDLE;
                cnt[ch]   <= ZERO;
            end
        end else begin
            sync1 <= raw_press;
            sync2 <= sync1;
            pulse <= pulse_next;
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= state_next[ch];
                cnt[ch]   <= cnt_next[ch];
            end
        end
    end

    // Next-state logic; a level is accepted after DEBOUNCE consecutive samples.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_next[ch] = state[ch];
            cnt_next[ch]   = cnt[ch];
            case (state[ch])
                IDLE: begin
                    if (sync2[ch]) begin
                        state_next[ch] = ARMING;
                        cnt_next[ch]   = ONE;
                    end else begin
                        cnt_next[ch]   = ZERO;
                    end
                end
                ARMING: begin
                    if (!sync2[ch]) begin
                        state_next[ch] = IDLE;
                        cnt_next[ch]   = ZERO;
                    end else if (cnt[ch] == LAST) begin
                        state_next[ch] = PRESSED;
                        cnt_next[ch]   = ZERO;
                    end else begin
                        cnt_next[ch]   = cnt[ch] + ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2[ch]) begin
                        state_next[ch] = RELEASING;
                        cnt_next[ch]   = ONE;
                    end
                end
                RELEASING: begin
                    if (sync2[ch]) begin
                        state_next[ch] = PRESSED;
                        cnt_next[ch]   = ZERO;
                    end else if (cnt[ch] == LAST) begin
                        state_next[ch] = IDLE;
                        cnt_next[ch]   = ZERO;
                    end else begin
                        cnt_next[ch]   = cnt[ch] + ONE;
                    end
                end
                default: begin
                    state_next[ch] = IDLE;
                    cnt_next[ch]   = ZERO;
                end
            endcase
        end
    end

    // Only the press-acceptance edge fires; a press accepted while locked is dropped.
    always_comb begin
        pulse_next = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            pulse_next[ch] = (state[ch] == ARMING) && sync2[ch] &&
                             (cnt[ch] == LAST) && !keys.lock;
        end
    end

    assign keys.L = pulse[0];
    assign keys.R = pulse[1];

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner: a run-length debounce model checked
// every cycle, plus literal latency and pulse-count expectations.
module tb_key_press_conditioner;

    localparam int DEB = 4;

    logic Clock = 1'b0;
    logic Reset;
    int   vectors     = 0;
    int   miscompares = 0;

    key_press_conditioner_if kif();

    key_press_conditioner #(
        .DEBOUNCE (DEB),
        .CNT_W    (8)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .keys  (kif)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        bit deb;
        int run;
        bit fire;
    } chan_t;

    // Accepted level flips once the sample differs from it DEB times in a row.
    function automatic chan_t stepChannel(input bit s, input bit deb, input int run, input bit lockNow);
        chan_t r;
        r.deb  = deb;
        r.run  = 0;
        r.fire = 1'b0;
        if (s != deb) begin
            if (run + 1 == DEB) begin
                r.deb  = s;
                r.fire = s & ~lockNow;
            end else begin
                r.run = run + 1;
            end
        end
        return r;
    endfunction

    bit [1:0] mHist1, mHist2, mDeb;
    int       mRunL, mRunR;
    bit       mExpL, mExpR;
    chan_t    stepL, stepR;

    always_comb begin
        stepL = stepChannel(mHist2[0], mDeb[0], mRunL, kif.lock);
        stepR = stepChannel(mHist2[1], mDeb[1], mRunR, kif.lock);
    end

    // Model keeps the raw key two edges deep before the debouncer sees it.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mHist1 <= 2'b00;
            mHist2 <= 2'b00;
            mDeb   <= 2'b00;
            mRunL  <= 0;
            mRunR  <= 0;
            mExpL  <= 1'b0;
            mExpR  <= 1'b0;
        end else begin
            mHist1 <= {~kif.key_r_n, ~kif.key_l_n};
            mHist2 <= mHist1;
            mDeb   <= {stepR.deb, stepL.deb};
            mRunL  <= stepL.run;
            mRunR  <= stepR.run;
            mExpL  <= stepL.fire;
            mExpR  <= stepR.fire;
        end
    end

    always @(negedge Clock) begin
        if (!Reset) begin
            vectors++;
            if (kif.L !== mExpL || kif.R !== mExpR) begin
                miscompares++;
                $display("[TB] FAIL model_cmp t=%0t: L=%0b R=%0b expected L=%0b R=%0b",
                         $time, kif.L, kif.R, mExpL, mExpR);
            end
        end
    end

    task automatic applyStimulus(input bit kl, input bit kr, input bit lk);
        kif.key_l_n = kl;
        kif.key_r_n = kr;
        kif.lock    = lk;
    endtask

    task automatic checkOutput(input string name, input bit expL, input bit expR);
        vectors++;
        if (kif.L !== expL || kif.R !== expR) begin
            miscompares++;
            $display("[TB] FAIL %s: L=%0b R=%0b expected L=%0b R=%0b",
                     name, kif.L, kif.R, expL, expR);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: counted %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic countPulses(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        repeat (n) begin
            @(negedge Clock);
            cl += int'(kif.L);
            cr += int'(kif.R);
        end
    endtask

    // Inputs already applied at a negedge; expect the pulse on the 6th negedge.
    task automatic checkLatency(input string name, input bit expL, input bit expR);
        for (int i = 1; i <= DEB + 1; i++) begin
            @(negedge Clock);
            checkOutput({name, "_quiet"}, 1'b0, 1'b0);
        end
        @(negedge Clock);
        checkOutput({name, "_pulse"}, expL, expR);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cl, cr;
        Reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge Clock);
        checkOutput("reset_state", 1'b0, 1'b0);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);

        $display("[TB] clean left press and hold");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkLatency("t1", 1'b1, 1'b0);
        @(negedge Clock);
        checkOutput("t1_clear", 1'b0, 1'b0);
        countPulses(20, cl, cr);
        checkCount("t1_hold_L", cl, 0);
        checkCount("t1_hold_R", cr, 0);

        $display("[TB] press bounce");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge Clock);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge Clock);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        applyStimulus(1'b1, 1'b1, 1'b0);
        countPulses(12, cl, cr);
        checkCount("t2_bounce_L", cl, 0);

        $display("[TB] release bounce");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkLatency("t3_press", 1'b1, 1'b0);
        repeat (4) @(negedge Clock);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge Clock);
        applyStimulus(1'b0, 1'b1, 1'b0);
        countPulses(10, cl, cr);
        checkCount("t3_rel_bounce_L", cl, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        countPulses(8, cl, cr);
        checkCount("t3_release_L", cl, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        countPulses(8, cl, cr);
        checkCount("t3_repress_L", cl, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge Clock);

        $display("[TB] simultaneous presses");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkLatency("t4", 1'b1, 1'b1);
        @(negedge Clock);
        checkOutput("t4_clear", 1'b0, 1'b0);
        countPulses(10, cl, cr);
        checkCount("t4_hold_L", cl, 0);
        checkCount("t4_hold_R", cr, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge Clock);

        $display("[TB] lock gating");
        applyStimulus(1'b1, 1'b0, 1'b1);
        countPulses(10, cl, cr);
        checkCount("t5_locked_R", cr, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        countPulses(10, cl, cr);
        checkCount("t5_unlocked_held_R", cr, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge Clock);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkLatency("t5_repress", 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge Clock);

        $display("[TB] asynchronous reset mid-press");
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b1;
        #1 checkOutput("t6_reset_mid_arming", 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        checkLatency("t6_after_reset", 1'b1, 1'b0);
        #1 Reset = 1'b1;
        #1 checkOutput("t6_reset_kills_pulse", 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
